// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // A BCD nibble at or above this value gets the add-3 correction before a shift
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Digit shown on both positions when the value cannot fit in two digits
  localparam logic [3:0] SAT_DIGIT  = 4'd9;

  // Largest value representable on the two-digit display
  localparam int unsigned DEC_LIMIT = 99;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a value producer and the converter.
interface bin2bcd_seq_if #(
  parameter int WIDTH = 7
);
  import bin2bcd_seq_pkg::*;

  logic             start;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [3:0]       BCD1;
  logic [3:0]       BCD0;
  logic             ovf;

  // Producer side: issues requests, observes results
  modport master (
    output start, bin,
    input  busy, done, BCD1, BCD0, ovf
  );

  // Converter side
  modport slave (
    input  start, bin,
    output busy, done, BCD1, BCD0, ovf
  );

endinterface

// File: rtl/bin2bcd_seq_adj3.sv
// Double-dabble correction: a nibble of 5..15 gets +3 (4-bit wrap) before the shift.
module bcd_adj3
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  // Conditional add-3 on a single BCD digit
  always_comb begin
    nib_out = nib_in;
    if (nib_in >= ADJ_THRESH) nib_out = nib_in + ADJ_ADD;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, saturating at 99.
// Outputs are registered and only updated once per conversion.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input logic          clk,
  input logic          rst,
  bin2bcd_seq_if.slave bus
);

  if (WIDTH < 4 || WIDTH > 9) begin : g_width_check
    $error("bin2bcd_seq: WIDTH must be in 4..9");
  end

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [3:0]       hun, hun_next;
  logic [3:0]       ten, ten_next;
  logic [3:0]       one, one_next;
  logic [3:0]       cnt, cnt_next;
  logic [3:0]       bcd1_q, bcd1_next;
  logic [3:0]       bcd0_q, bcd0_next;
  logic             ovf_q, ovf_next;
  logic             done_q, done_next;

  logic [3:0]       hun_adj, ten_adj, one_adj;
  logic             hun_msb_unused;

  bcd_adj3 u_adj_hun (.nib_in(hun), .nib_out(hun_adj));
  bcd_adj3 u_adj_ten (.nib_in(ten), .nib_out(ten_adj));
  bcd_adj3 u_adj_one (.nib_in(one), .nib_out(one_adj));

  // State, shift chain and output registers; reset overrides any start request
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      hun    <= '0;
      ten    <= '0;
      one    <= '0;
      cnt    <= '0;
      bcd1_q <= '0;
      bcd0_q <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      shreg  <= shreg_next;
      hun    <= hun_next;
      ten    <= ten_next;
      one    <= one_next;
      cnt    <= cnt_next;
      bcd1_q <= bcd1_next;
      bcd0_q <= bcd0_next;
      ovf_q  <= ovf_next;
      done_q <= done_next;
    end
  end

  // Next-state logic: capture in IDLE, adjust-then-shift in SHIFT, publish in DONE
  always_comb begin
    state_next     = state;
    shreg_next     = shreg;
    hun_next       = hun;
    ten_next       = ten;
    one_next       = one;
    cnt_next       = cnt;
    bcd1_next      = bcd1_q;
    bcd0_next      = bcd0_q;
    ovf_next       = ovf_q;
    done_next      = 1'b0;
    hun_msb_unused = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          shreg_next = bus.bin;
          hun_next   = '0;
          ten_next   = '0;
          one_next   = '0;
          cnt_next   = 4'(WIDTH);
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Hundreds never reaches 8 for WIDTH<=9, so its MSB shifted out is always 0
        {hun_msb_unused, hun_next, ten_next, one_next, shreg_next} =
          {hun_adj, ten_adj, one_adj, shreg, 1'b0};
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (hun != 4'd0) begin
          bcd1_next = SAT_DIGIT;
          bcd0_next = SAT_DIGIT;
          ovf_next  = 1'b1;
        end else begin
          bcd1_next = ten;
          bcd0_next = one;
          ovf_next  = 1'b0;
        end
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output drive; busy follows the state so it drops in the done cycle
  always_comb begin
    bus.busy = (state != ST_IDLE);
    bus.done = done_q;
    bus.BCD1 = bcd1_q;
    bus.BCD0 = bcd0_q;
    bus.ovf  = ovf_q;
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq at WIDTH 7, 9 and 4.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic       start_s [3];
  logic [8:0] bin_s   [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic       ovf_s   [3];
  logic [3:0] b1_s    [3];
  logic [3:0] b0_s    [3];

  int unsigned width_of [3] = '{7, 9, 4};
  int unsigned prev1    [3];
  int unsigned prev0    [3];
  int unsigned prevo    [3];

  bin2bcd_seq_if #(.WIDTH(7)) if7 ();
  bin2bcd_seq_if #(.WIDTH(9)) if9 ();
  bin2bcd_seq_if #(.WIDTH(4)) if4 ();

  assign if7.start = start_s[0];
  assign if9.start = start_s[1];
  assign if4.start = start_s[2];
  assign if7.bin   = bin_s[0][6:0];
  assign if9.bin   = bin_s[1][8:0];
  assign if4.bin   = bin_s[2][3:0];

  assign busy_s[0] = if7.busy;  assign done_s[0] = if7.done;  assign ovf_s[0] = if7.ovf;
  assign b1_s[0]   = if7.BCD1;  assign b0_s[0]   = if7.BCD0;
  assign busy_s[1] = if9.busy;  assign done_s[1] = if9.done;  assign ovf_s[1] = if9.ovf;
  assign b1_s[1]   = if9.BCD1;  assign b0_s[1]   = if9.BCD0;
  assign busy_s[2] = if4.busy;  assign done_s[2] = if4.done;  assign ovf_s[2] = if4.ovf;
  assign b1_s[2]   = if4.BCD1;  assign b0_s[2]   = if4.BCD0;

  bin2bcd_seq #(.WIDTH(7)) dut7 (.clk(clk), .rst(rst), .bus(if7));
  bin2bcd_seq #(.WIDTH(9)) dut9 (.clk(clk), .rst(rst), .bus(if9));
  bin2bcd_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain decimal arithmetic, saturating above two digits
  task automatic model(input int unsigned v, output int unsigned t, output int unsigned o,
                       output int unsigned ov);
    if (v > 99) begin
      t = 9; o = 9; ov = 1;
    end else begin
      t = v / 10; o = v % 10; ov = 0;
    end
  endtask

  task automatic expect_all(input int sel, input string tag, input int unsigned e1,
                            input int unsigned e0, input int unsigned eo,
                            input int unsigned ebusy, input int unsigned edone);
    check($sformatf("%s.w%0d.busy", tag, width_of[sel]), int'(busy_s[sel]), ebusy);
    check($sformatf("%s.w%0d.done", tag, width_of[sel]), int'(done_s[sel]), edone);
    check($sformatf("%s.w%0d.bcd1", tag, width_of[sel]), int'(b1_s[sel]), e1);
    check($sformatf("%s.w%0d.bcd0", tag, width_of[sel]), int'(b0_s[sel]), e0);
    check($sformatf("%s.w%0d.ovf",  tag, width_of[sel]), int'(ovf_s[sel]), eo);
  endtask

  // Called just after a negedge in an idle cycle; start is taken at the next posedge
  task automatic convert(input int sel, input int unsigned v);
    int unsigned t, o, ov;
    int unsigned w;
    w = width_of[sel];
    model(v, t, o, ov);
    start_s[sel] = 1'b1;
    bin_s[sel]   = 9'(v);
    @(posedge clk);
    #1;
    start_s[sel] = 1'b0;
    bin_s[sel]   = 9'($urandom);
    for (int unsigned i = 0; i <= w; i++) begin
      @(negedge clk);
      expect_all(sel, $sformatf("hold%0d.v%0d", i, v), prev1[sel], prev0[sel], prevo[sel], 1, 0);
    end
    @(negedge clk);
    expect_all(sel, $sformatf("result.v%0d", v), t, o, ov, 0, 1);
    prev1[sel] = t; prev0[sel] = o; prevo[sel] = ov;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b1;
      bin_s[i]   = 9'd55;
      prev1[i] = 0; prev0[i] = 0; prevo[i] = 0;
    end

    // Reset held two cycles with start asserted
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) expect_all(i, "reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) start_s[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) expect_all(i, "post_reset", 0, 0, 0, 0, 0);

    // Basic and saturation boundaries
    convert(0, 59);
    convert(0, 0);
    convert(0, 99);
    convert(0, 100);
    convert(0, 127);

    // Capture at start edge; start during busy ignored; held start restarts at E9
    start_s[0] = 1'b1;
    bin_s[0]   = 9'd42;
    @(posedge clk);
    #1;
    bin_s[0] = 9'd17;
    repeat (8) begin
      @(negedge clk);
      expect_all(0, "ign.first_hold", prev1[0], prev0[0], prevo[0], 1, 0);
    end
    @(negedge clk);
    expect_all(0, "ign.first", 4, 2, 0, 0, 1);
    @(negedge clk);
    expect_all(0, "ign.restart", 4, 2, 0, 1, 0);
    start_s[0] = 1'b0;
    repeat (7) begin
      @(negedge clk);
      expect_all(0, "ign.second_hold", 4, 2, 0, 1, 0);
    end
    @(negedge clk);
    expect_all(0, "ign.second", 1, 7, 0, 0, 1);
    prev1[0] = 1; prev0[0] = 7; prevo[0] = 0;

    // Reset during the third SHIFT cycle aborts the conversion
    start_s[0] = 1'b1;
    bin_s[0]   = 9'd42;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expect_all(0, "midrst", 0, 0, 0, 0, 0);
    prev1[0] = 0; prev0[0] = 0; prevo[0] = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("midrst.no_done", int'(done_s[0]), 0);
      check("midrst.no_busy", int'(busy_s[0]), 0);
    end
    convert(0, 42);

    // Randomized values at WIDTH 7
    for (int i = 0; i < 15; i++) convert(0, $urandom_range(0, 127));

    // WIDTH 9 and WIDTH 4 sweep
    convert(1, 511);
    convert(1, 99);
    convert(1, 100);
    for (int i = 0; i < 5; i++) convert(1, $urandom_range(0, 511));
    convert(2, 15);
    convert(2, 0);
    for (int i = 0; i < 5; i++) convert(2, $urandom_range(0, 15));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
